// File: rtl/rf_wb_arbiter.sv
// Two-port register-file writeback arbiter with a 32-entry pending-write scoreboard.
// Define RF_WB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module rf_wb_arbiter #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [4:0]        wb0_id,
  input  logic [DWIDTH-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [4:0]        wb1_id,
  input  logic [DWIDTH-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_id,
  input  logic [4:0]        q_rs1_id,
  input  logic [4:0]        q_rs2_id,
  output logic              q_rs1_busy,
  output logic              q_rs2_busy,
  output logic              rf_we,
  output logic [4:0]        rf_rdst_id,
  output logic [DWIDTH-1:0] rf_rdst
);

  logic [31:0]       busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rdst_id_q, rdst_id_d;
  logic [DWIDTH-1:0] rdst_q, rdst_d;
  logic              pick1;
  logic              xfer0, xfer1;

`ifdef RF_WB_RR_EN
  // ptr_q = 1 means port 1 is favoured on contention
  logic ptr_q, ptr_d;

  always_comb begin
    pick1 = wb1_valid && (!wb0_valid || ptr_q);
    ptr_d = ptr_q;
    if (xfer0) begin
      ptr_d = 1'b1;
    end else if (xfer1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    pick1 = wb1_valid && !wb0_valid;
  end
`endif

  always_comb begin
    wb0_ready = !rst && wb0_valid && !pick1;
    wb1_ready = !rst && pick1;
    xfer0     = wb0_valid && wb0_ready;
    xfer1     = wb1_valid && wb1_ready;
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rdst_id_d = rdst_id_q;
    rdst_d    = rdst_q;
    busy_d    = busy_q;
    if (xfer0 || xfer1) begin
      rdst_id_d = xfer1 ? wb1_id : wb0_id;
      rdst_d    = xfer1 ? wb1_data : wb0_data;
      rf_we_d   = (rdst_id_d != 5'd0);
    end
    // Clear at the commit edge first so a same-edge issue to that id wins.
    if (rf_we_q) begin
      busy_d[rdst_id_q] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_id] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rdst_id_q <= 5'd0;
      rdst_q    <= '0;
      busy_q    <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rdst_id_q <= rdst_id_d;
      rdst_q    <= rdst_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    rf_we      = rf_we_q;
    rf_rdst_id = rdst_id_q;
    rf_rdst    = rdst_q;
    q_rs1_busy = busy_q[q_rs1_id];
    q_rs2_busy = busy_q[q_rs2_id];
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus queues expected grants, writes and
// observations by cycle; a monitor on the falling edge pops and compares them.
module tb_rf_wb_arbiter;
  localparam int DW = 32;

  logic          clk, rst;
  logic          wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]    wb0_id, wb1_id, iss_id, q_rs1_id, q_rs2_id, rf_rdst_id;
  logic [DW-1:0] wb0_data, wb1_data, rf_rdst;
  logic          iss_valid, q_rs1_busy, q_rs2_busy, rf_we;

  rf_wb_arbiter #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .iss_valid(iss_valid), .iss_id(iss_id),
    .q_rs1_id(q_rs1_id), .q_rs2_id(q_rs2_id), .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
    .rf_we(rf_we), .rf_rdst_id(rf_rdst_id), .rf_rdst(rf_rdst)
  );

  typedef struct { int cyc; int port; } grant_t;
  typedef struct { int cyc; logic [4:0] id; logic [DW-1:0] data; } wr_t;
  // kind: 0 rs1_busy, 1 rs2_busy, 2 rf_rdst_id, 3 rf_rdst, 4 rf_we
  typedef struct { int cyc; int kind; logic [DW-1:0] val; } chk_t;

  grant_t gq[$];
  wr_t    wq[$];
  chk_t   cq[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     done = 0;

`ifdef RF_WB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d, required < 20000)", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int c, input int p);
    grant_t e;
    int i = 0;
    e.cyc = c; e.port = p;
    while (i < gq.size() && gq[i].cyc <= c) i++;
    gq.insert(i, e);
  endtask

  task automatic exp_wr(input int c, input logic [4:0] id, input logic [DW-1:0] d);
    wr_t e;
    int i = 0;
    e.cyc = c; e.id = id; e.data = d;
    while (i < wq.size() && wq[i].cyc <= c) i++;
    wq.insert(i, e);
  endtask

  task automatic exp_chk(input int c, input int kind, input logic [DW-1:0] v);
    chk_t e;
    int i = 0;
    e.cyc = c; e.kind = kind; e.val = v;
    while (i < cq.size() && cq[i].cyc <= c) i++;
    cq.insert(i, e);
  endtask

  // Monitor
  initial begin
    bit            prev_rst = 1'b1;
    bit            pend0 = 1'b0, pend1 = 1'b0;
    logic [4:0]    pid0, pid1;
    logic [DW-1:0] pd0, pd1, act;
    grant_t        g;
    wr_t           w;
    chk_t          c;
    forever begin
      @(negedge clk);
      checks++;
      if (wb0_ready && wb1_ready) begin
        errors++;
        $display("FAIL one_ready cyc %0d: both readys high, required at most one", cyc);
      end
      if (rst) begin
        checks++;
        if (wb0_ready || wb1_ready) begin
          errors++;
          $display("FAIL rst_ready cyc %0d: ready0=%0b ready1=%0b, required 0", cyc,
                   wb0_ready, wb1_ready);
        end
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        g = gq.pop_front();
        checks++; errors++;
        $display("FAIL grant_missing: port %0d expected at cyc %0d, not observed", g.port,
                 g.cyc);
      end
      if ((wb0_valid && wb0_ready) || (wb1_valid && wb1_ready)) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL grant_extra cyc %0d: ready0=%0b ready1=%0b, required none", cyc,
                   wb0_ready, wb1_ready);
        end else begin
          g = gq.pop_front();
          if (g.cyc != cyc || g.port != (wb1_ready ? 1 : 0)) begin
            errors++;
            $display("FAIL grant cyc %0d: port %0d, required port %0d at cyc %0d", cyc,
                     wb1_ready ? 1 : 0, g.port, g.cyc);
          end
        end
      end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        w = wq.pop_front();
        checks++; errors++;
        $display("FAIL write_missing: id %0d expected at cyc %0d, not observed", w.id, w.cyc);
      end
      if (rf_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL write_extra cyc %0d: id %0d data %h, required no write", cyc,
                   rf_rdst_id, rf_rdst);
        end else begin
          w = wq.pop_front();
          if (w.cyc != cyc || w.id != rf_rdst_id || w.data != rf_rdst) begin
            errors++;
            $display("FAIL write cyc %0d: id %0d data %h, required id %0d data %h at cyc %0d",
                     cyc, rf_rdst_id, rf_rdst, w.id, w.data, w.cyc);
          end
        end
      end
      while (cq.size() > 0 && cq[0].cyc <= cyc) begin
        c = cq.pop_front();
        checks++;
        unique case (c.kind)
          0:       act = DW'(q_rs1_busy);
          1:       act = DW'(q_rs2_busy);
          2:       act = DW'(rf_rdst_id);
          3:       act = rf_rdst;
          default: act = DW'(rf_we);
        endcase
        if (c.cyc != cyc || act != c.val) begin
          errors++;
          $display("FAIL obs kind %0d cyc %0d: got %h, required %h at cyc %0d", c.kind, cyc,
                   act, c.val, c.cyc);
        end
      end
      // A requester that was not granted must hold its request.
      if (!prev_rst && pend0) begin
        checks++;
        if (!wb0_valid || wb0_id != pid0 || wb0_data != pd0) begin
          errors++;
          $display("FAIL hold0 cyc %0d: valid %0b id %0d data %h, required 1 %0d %h", cyc,
                   wb0_valid, wb0_id, wb0_data, pid0, pd0);
        end
      end
      if (!prev_rst && pend1) begin
        checks++;
        if (!wb1_valid || wb1_id != pid1 || wb1_data != pd1) begin
          errors++;
          $display("FAIL hold1 cyc %0d: valid %0b id %0d data %h, required 1 %0d %h", cyc,
                   wb1_valid, wb1_id, wb1_data, pid1, pd1);
        end
      end
      pend0 = wb0_valid && !wb0_ready; pid0 = wb0_id; pd0 = wb0_data;
      pend1 = wb1_valid && !wb1_ready; pid1 = wb1_id; pd1 = wb1_data;
      prev_rst = rst;
    end
  end

  // Stimulus
  initial begin
    int            c, m, p;
    logic [DW-1:0] d0, d1;
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_id = 5'd4; wb0_data = 32'h0000_00AA;
    wb1_valid = 1'b0; wb1_id = 5'd0; wb1_data = '0;
    iss_valid = 1'b1; iss_id = 5'd9;
    q_rs1_id = 5'd0; q_rs2_id = 5'd0;
    tick(); tick();

    // Reset state; the request and issue offered during reset are dropped
    rst = 1'b0; wb0_valid = 1'b0; iss_valid = 1'b0; q_rs1_id = 5'd9;
    c = cyc;
    exp_chk(c, 0, 0); exp_chk(c, 1, 0); exp_chk(c, 2, 0); exp_chk(c, 3, 0); exp_chk(c, 4, 0);
    tick();

    // Single write
    c = cyc;
    wb0_valid = 1'b1; wb0_id = 5'd5; wb0_data = 32'hDEAD_BEEF;
    exp_grant(c, 0); exp_wr(c + 1, 5'd5, 32'hDEAD_BEEF);
    exp_chk(c + 2, 4, 0); exp_chk(c + 2, 2, 5); exp_chk(c + 2, 3, 32'hDEAD_BEEF);
    tick(); wb0_valid = 1'b0; tick(); tick();

    // x0 write is granted but never committed
    c = cyc;
    wb1_valid = 1'b1; wb1_id = 5'd0; wb1_data = 32'h0000_1234;
    exp_grant(c, 1); exp_chk(c + 1, 4, 0);
    tick(); wb1_valid = 1'b0; tick();

    // Scoreboard set, clear, and set-wins collision
    c = cyc;
    iss_valid = 1'b1; iss_id = 5'd7; q_rs1_id = 5'd7; q_rs2_id = 5'd7;
    exp_chk(c, 0, 0); exp_chk(c + 1, 0, 1); exp_chk(c + 1, 1, 1);
    tick(); iss_valid = 1'b0; tick();
    m = cyc;
    wb0_valid = 1'b1; wb0_id = 5'd7; wb0_data = 32'h0000_0077;
    exp_grant(m, 0); exp_wr(m + 1, 5'd7, 32'h0000_0077);
    exp_chk(m, 0, 1); exp_chk(m + 1, 0, 1); exp_chk(m + 2, 0, 0);
    tick(); wb0_valid = 1'b0; tick(); tick();
    p = cyc;
    wb0_valid = 1'b1; wb0_id = 5'd7; wb0_data = 32'h0000_0078;
    exp_grant(p, 0); exp_wr(p + 1, 5'd7, 32'h0000_0078);
    exp_chk(p + 2, 0, 1); exp_chk(p + 3, 0, 1);
    tick(); wb0_valid = 1'b0; iss_valid = 1'b1; iss_id = 5'd7;
    tick(); iss_valid = 1'b0; tick(); tick();

    // Contention from reset
    rst = 1'b1; tick(); rst = 1'b0;
    d0 = 32'hA000_0000; d1 = 32'hB000_0000;
    wb0_valid = 1'b1; wb0_id = 5'd10; wb0_data = d0;
    wb1_valid = 1'b1; wb1_id = 5'd11; wb1_data = d1;
    for (int i = 0; i < 4; i++) begin
      if (RrEn && (i % 2 == 1)) begin
        exp_grant(cyc, 1); exp_wr(cyc + 1, 5'd11, d1);
        tick(); d1 = d1 + 1; wb1_data = d1;
      end else begin
        exp_grant(cyc, 0); exp_wr(cyc + 1, 5'd10, d0);
        tick(); d0 = d0 + 1; wb0_data = d0;
      end
    end
    wb0_valid = 1'b0;
    exp_grant(cyc, 1); exp_wr(cyc + 1, 5'd11, d1);
    tick(); wb1_valid = 1'b0; tick();

    // Reset while a write is committing and busy[3] is set
    iss_valid = 1'b1; iss_id = 5'd3; q_rs1_id = 5'd3;
    tick();
    iss_valid = 1'b0;
    c = cyc;
    wb0_valid = 1'b1; wb0_id = 5'd12; wb0_data = 32'h0000_00CC;
    exp_chk(c, 0, 1); exp_grant(c, 0); exp_wr(c + 1, 5'd12, 32'h0000_00CC);
    tick();
    rst = 1'b1;
    wb0_id = 5'd14; wb0_data = 32'h0000_00EE;
    wb1_valid = 1'b1; wb1_id = 5'd13; wb1_data = 32'h0000_00DD;
    tick();
    rst = 1'b0;
    c = cyc;
    exp_chk(c, 4, 0); exp_chk(c, 0, 0); exp_chk(c, 1, 0);
    exp_grant(c, 0); exp_wr(c + 1, 5'd14, 32'h0000_00EE);
    tick(); wb0_valid = 1'b0;
    exp_grant(cyc, 1); exp_wr(cyc + 1, 5'd13, 32'h0000_00DD);
    tick(); wb1_valid = 1'b0;
    tick(); tick(); tick();

    checks++;
    if (gq.size() != 0 || wq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending grants %0d writes %0d obs %0d, required 0 0 0",
               gq.size(), wq.size(), cq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
